// File: rtl/button_event_detector.sv
// Button event detector: synchronizes a raw button pin and confirms each edge through an
// external settle timer, then emits single-cycle press, release and long-press events.
module button_event_detector #(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter bit          ACTIVE_LOW       = 1'b1,
  parameter int unsigned LONG_PRESS_TICKS = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_raw_i,
  input  logic timer_done_i,
  output logic timer_start_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic btn_level_o,
  output logic busy_o
);

  localparam int unsigned HOLD_W_RAW = $clog2(LONG_PRESS_TICKS + 1);
  localparam int unsigned HOLD_W     = (HOLD_W_RAW < 1) ? 1 : HOLD_W_RAW;
  localparam int unsigned LAST_TICK  = (LONG_PRESS_TICKS > 0) ? LONG_PRESS_TICKS - 1 : 0;
  localparam bit          LP_EN      = (LONG_PRESS_TICKS > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM_P,
    S_WAIT_P,
    S_HELD_ARM,
    S_HELD,
    S_ARM_R,
    S_WAIT_R
  } state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                long_sent_q, long_sent_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                btn_s;
  logic                done_ok;
  logic                last_tick;

  logic timer_start_q, timer_start_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_press_q, long_press_d;
  logic btn_level_q, btn_level_d;
  logic busy_q, busy_d;

  // Synchronizer resets to the released pin level so reset release never looks like a press
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
    end
  end

  assign btn_s     = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
  // A done pulse coinciding with a fresh start belongs to the superseded period
  assign done_ok   = timer_done_i & ~timer_start_q;
  assign last_tick = (hold_cnt_q == HOLD_W'(LAST_TICK));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      long_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      long_sent_q <= long_sent_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    long_sent_d = long_sent_q;
    case (state_q)
      S_IDLE:     if (btn_s) state_d = S_ARM_P;
      S_ARM_P:    state_d = S_WAIT_P;
      S_WAIT_P: begin
        if (done_ok) begin
          if (btn_s) begin
            state_d     = S_HELD_ARM;
            hold_cnt_d  = '0;
            long_sent_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HELD_ARM: state_d = S_HELD;
      S_HELD: begin
        // Release has priority over a coincident hold tick
        if (!btn_s) begin
          state_d = S_ARM_R;
        end else if (done_ok && !long_sent_q && LP_EN) begin
          state_d = S_HELD_ARM;
          if (last_tick) long_sent_d = 1'b1;
          else           hold_cnt_d  = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_ARM_R:    state_d = S_WAIT_R;
      S_WAIT_R: begin
        if (done_ok) state_d = btn_s ? S_HELD_ARM : S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_start_d = 1'b0;
    press_d       = 1'b0;
    release_d     = 1'b0;
    long_press_d  = 1'b0;
    btn_level_d   = btn_level_q;
    busy_d        = (state_d != S_IDLE);
    case (state_q)
      S_ARM_P, S_ARM_R: timer_start_d = 1'b1;
      S_HELD_ARM:       timer_start_d = LP_EN & ~long_sent_q;
      S_WAIT_P: begin
        if (done_ok && btn_s) begin
          press_d     = 1'b1;
          btn_level_d = 1'b1;
        end
      end
      S_HELD: begin
        if (btn_s && done_ok && !long_sent_q && LP_EN && last_tick) long_press_d = 1'b1;
      end
      S_WAIT_R: begin
        if (done_ok && !btn_s) begin
          release_d   = 1'b1;
          btn_level_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_start_q <= 1'b0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      long_press_q  <= 1'b0;
      btn_level_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      timer_start_q <= timer_start_d;
      press_q       <= press_d;
      release_q     <= release_d;
      long_press_q  <= long_press_d;
      btn_level_q   <= btn_level_d;
      busy_q        <= busy_d;
    end
  end

  assign timer_start_o = timer_start_q;
  assign press_o       = press_q;
  assign release_o     = release_q;
  assign long_press_o  = long_press_q;
  assign btn_level_o   = btn_level_q;
  assign busy_o        = busy_q;

endmodule
